// File: rtl/contador_pkg.sv
// contador_pkg
// Shared types for the up/down counter driver: the command opcode enum,
// the driver FSM state enum, terminal-count values of the 4-bit counter
// and the model step helper.
package contador_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_UP    = 2'd2,
        OP_DOWN  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic [3:0] CNT_MAX = 4'd15;
    localparam logic [3:0] CNT_MIN = 4'd0;

    // One count step of the modelled counter; wraps naturally mod 16.
    function automatic logic [3:0] step_value(input logic [3:0] value, input logic up);
        return up ? (value + 4'd1) : (value - 4'd1);
    endfunction

endpackage

// File: rtl/contador_pulse_timer.sv
// contador_pulse_timer
// 4-bit down-counter that times pulse and gap phases. A load of N makes
// 'expired' high during the N-th cycle after the load, so the owner can
// end the phase on that cycle's closing edge (phase lasts exactly N cycles).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        restart the timer with load_val (1..15)
//   load_val    phase length in clk cycles
//   expired     registered flag, high in the last cycle of the phase
module contador_pulse_timer
    import contador_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expired
);

    logic [3:0] cnt_r;
    logic       expired_r;

    // Down-count, flagging ahead of time the cycle in which the count reads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 4'd0;
            expired_r <= 1'b0;
        end else if (load) begin
            cnt_r     <= load_val;
            expired_r <= (load_val == 4'd1);
        end else if (cnt_r != 4'd0) begin
            cnt_r     <= cnt_r - 4'd1;
            expired_r <= (cnt_r == 4'd2);
        end else begin
            cnt_r     <= cnt_r;
            expired_r <= 1'b0;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/contador_driver.sv
// contador_driver
// Drives a 4-bit up/down counter with master reset, parallel load and
// separate up/down clocks, keeps a model of its value and checks the
// counter's Q and terminal-count outputs against that model.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op, cmd_data        CLEAR/LOAD/UP/DOWN, load value or step count
//   MR, PL, CPU, CPD        counter controls, all straight from flops
//   P0..P3                  parallel data, P0 = value bit 3
//   Q0..Q3, TCU, TCD        counter outputs, Q0 = LSB
//   exp_count, exp_valid    modelled value and whether it is known
//   done                    one-cycle completion pulse
//   mismatch                sticky error, cleared only by reset
//   carry_evt, borrow_evt   one pulse per observed terminal count
module contador_driver
    import contador_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       MR,
    output logic       PL,
    output logic       CPU,
    output logic       CPD,
    output logic       P0,
    output logic       P1,
    output logic       P2,
    output logic       P3,
    input  logic       Q0,
    input  logic       Q1,
    input  logic       Q2,
    input  logic       Q3,
    input  logic       TCU,
    input  logic       TCD,
    output logic [3:0] exp_count,
    output logic       exp_valid,
    output logic       done,
    output logic       mismatch,
    output logic       carry_evt,
    output logic       borrow_evt
);

    localparam logic [3:0] PW4 = 4'(PULSE_W);
    localparam logic [3:0] GW4 = 4'(GAP_W);

    state_e     state_r;
    cmd_op_e    op_r;
    logic [3:0] steps_r;
    logic [3:0] exp_count_r;
    logic       exp_valid_r;
    logic       mr_r, pl_r, cpu_r, cpd_r;
    logic       p0_r, p1_r, p2_r, p3_r;
    logic       done_r, mismatch_r, carry_evt_r, borrow_evt_r;
    logic       carry_seen_r, borrow_seen_r;
    logic       cmd_ready_r;

    cmd_op_e    op_s;
    logic       accept_s;
    logic       step_op_s;
    logic       more_steps_s;
    logic [3:0] q_s;
    logic       up_low_s, down_low_s;
    logic       tcu_exp_s, tcd_exp_s;
    logic       tc_err_s, q_err_s;
    logic       timer_load_s;
    logic [3:0] timer_val_s;
    logic       timer_exp_s;

    assign op_s         = cmd_op_e'(cmd_op);
    assign accept_s     = cmd_valid & cmd_ready_r;
    assign step_op_s    = (op_s == OP_UP) || (op_s == OP_DOWN);
    assign more_steps_s = ((op_r == OP_UP) || (op_r == OP_DOWN)) && (steps_r != 4'd0);
    assign q_s          = {Q3, Q2, Q1, Q0};

    // The clock line is low exactly while the FSM sits in PULSE.
    assign up_low_s   = (state_r == ST_PULSE) && (op_r == OP_UP);
    assign down_low_s = (state_r == ST_PULSE) && (op_r == OP_DOWN);

    // Terminal count is only legitimately low at 15 (up) / 0 (down) while
    // the matching clock is low; every other observed level is an error.
    assign tcu_exp_s = ~(up_low_s && (exp_count_r == CNT_MAX));
    assign tcd_exp_s = ~(down_low_s && (exp_count_r == CNT_MIN));
    assign tc_err_s  = exp_valid_r && ((TCU != tcu_exp_s) || (TCD != tcd_exp_s));
    assign q_err_s   = (state_r == ST_CHECK) && exp_valid_r && (q_s != exp_count_r);

    // Timer restarts: on entry to each pulse phase and to each gap phase.
    always_comb begin
        timer_load_s = 1'b0;
        timer_val_s  = PW4;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !(step_op_s && (cmd_data == 4'd0))) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = PW4;
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            ST_CLR, ST_LOAD, ST_PULSE: begin
                if (timer_exp_s) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = GW4;
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            ST_CHECK: begin
                if (more_steps_s) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = PW4;
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            default: begin
                timer_load_s = 1'b0;
            end
        endcase
    end

    contador_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .expired  (timer_exp_s)
    );

    // Driver FSM with registered counter controls, model and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            op_r          <= OP_CLEAR;
            steps_r       <= 4'd0;
            exp_count_r   <= 4'd0;
            exp_valid_r   <= 1'b0;
            mr_r          <= 1'b0;
            pl_r          <= 1'b1;
            cpu_r         <= 1'b1;
            cpd_r         <= 1'b1;
            p0_r          <= 1'b0;
            p1_r          <= 1'b0;
            p2_r          <= 1'b0;
            p3_r          <= 1'b0;
            done_r        <= 1'b0;
            mismatch_r    <= 1'b0;
            carry_evt_r   <= 1'b0;
            borrow_evt_r  <= 1'b0;
            carry_seen_r  <= 1'b0;
            borrow_seen_r <= 1'b0;
            cmd_ready_r   <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            carry_evt_r  <= 1'b0;
            borrow_evt_r <= 1'b0;

            if (tc_err_s || q_err_s) begin
                mismatch_r <= 1'b1;
            end

            // One event per pulse even if TC stays low for several cycles.
            if (up_low_s && !TCU && !carry_seen_r) begin
                carry_evt_r  <= 1'b1;
                carry_seen_r <= 1'b1;
            end
            if (down_low_s && !TCD && !borrow_seen_r) begin
                borrow_evt_r  <= 1'b1;
                borrow_seen_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    cmd_ready_r <= 1'b1;
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        op_r        <= op_s;
                        case (op_s)
                            OP_CLEAR: begin
                                steps_r <= 4'd0;
                                mr_r    <= 1'b1;
                                state_r <= ST_CLR;
                            end
                            OP_LOAD: begin
                                steps_r <= 4'd0;
                                p0_r    <= cmd_data[3];
                                p1_r    <= cmd_data[2];
                                p2_r    <= cmd_data[1];
                                p3_r    <= cmd_data[0];
                                pl_r    <= 1'b0;
                                state_r <= ST_LOAD;
                            end
                            OP_UP, OP_DOWN: begin
                                steps_r <= cmd_data;
                                if (cmd_data == 4'd0) begin
                                    done_r  <= 1'b1;
                                    state_r <= ST_DONE;
                                end else begin
                                    cpu_r         <= (op_s != OP_UP);
                                    cpd_r         <= (op_s != OP_DOWN);
                                    carry_seen_r  <= 1'b0;
                                    borrow_seen_r <= 1'b0;
                                    state_r       <= ST_PULSE;
                                end
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_CLR: begin
                    if (timer_exp_s) begin
                        mr_r        <= 1'b0;
                        exp_count_r <= 4'd0;
                        exp_valid_r <= 1'b1;
                        state_r     <= ST_GAP;
                    end
                end
                ST_LOAD: begin
                    if (timer_exp_s) begin
                        pl_r        <= 1'b1;
                        exp_count_r <= {p0_r, p1_r, p2_r, p3_r};
                        exp_valid_r <= 1'b1;
                        state_r     <= ST_GAP;
                    end
                end
                ST_PULSE: begin
                    // The model advances on the rising clock edge the counter sees.
                    if (timer_exp_s) begin
                        cpu_r       <= 1'b1;
                        cpd_r       <= 1'b1;
                        exp_count_r <= step_value(exp_count_r, op_r == OP_UP);
                        steps_r     <= steps_r - 4'd1;
                        state_r     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_exp_s) begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (more_steps_s) begin
                        cpu_r         <= (op_r != OP_UP);
                        cpd_r         <= (op_r != OP_DOWN);
                        carry_seen_r  <= 1'b0;
                        borrow_seen_r <= 1'b0;
                        state_r       <= ST_PULSE;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    mr_r    <= 1'b0;
                    pl_r    <= 1'b1;
                    cpu_r   <= 1'b1;
                    cpd_r   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign MR         = mr_r;
    assign PL         = pl_r;
    assign CPU        = cpu_r;
    assign CPD        = cpd_r;
    assign P0         = p0_r;
    assign P1         = p1_r;
    assign P2         = p2_r;
    assign P3         = p3_r;
    assign exp_count  = exp_count_r;
    assign exp_valid  = exp_valid_r;
    assign done       = done_r;
    assign mismatch   = mismatch_r;
    assign carry_evt  = carry_evt_r;
    assign borrow_evt = borrow_evt_r;

endmodule

// File: tb/tb_contador_driver.sv
// tb_contador_driver
// Directed bench: a behavioural 4-bit up/down counter answers the driver,
// monitors count control edges and event pulses, and each scenario compares
// against hand-computed values.
module tb_contador_driver;
    import contador_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       MR, PL, CPU, CPD;
    logic       P0, P1, P2, P3;
    logic       Q0, Q1, Q2, Q3, TCU, TCD;
    logic [3:0] exp_count;
    logic       exp_valid, done, mismatch, carry_evt, borrow_evt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    contador_driver #(.PULSE_W(2), .GAP_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .MR         (MR),
        .PL         (PL),
        .CPU        (CPU),
        .CPD        (CPD),
        .P0         (P0),
        .P1         (P1),
        .P2         (P2),
        .P3         (P3),
        .Q0         (Q0),
        .Q1         (Q1),
        .Q2         (Q2),
        .Q3         (Q3),
        .TCU        (TCU),
        .TCD        (TCD),
        .exp_count  (exp_count),
        .exp_valid  (exp_valid),
        .done       (done),
        .mismatch   (mismatch),
        .carry_evt  (carry_evt),
        .borrow_evt (borrow_evt)
    );

    // Behavioural counter: clear, load, count on rising clock lines.
    logic [3:0] cnt_m   = 4'd0;
    logic       cpu_p   = 1'b1;
    logic       cpd_p   = 1'b1;
    logic       fault_en = 1'b0;
    logic [3:0] fault_q  = 4'd0;

    always @(negedge clk) begin
        cpu_p <= CPU;
        cpd_p <= CPD;
        if (MR) cnt_m <= 4'd0;
        else if (!PL) cnt_m <= {P0, P1, P2, P3};
        else if (CPU && !cpu_p) cnt_m <= cnt_m + 4'd1;
        else if (CPD && !cpd_p) cnt_m <= cnt_m - 4'd1;
    end

    assign {Q3, Q2, Q1, Q0} = fault_en ? fault_q : cnt_m;
    assign TCU = !((cnt_m == 4'd15) && !CPU);
    assign TCD = !((cnt_m == 4'd0) && !CPD);

    // Monitors of accepted commands, clock edges, events and load data.
    int         acc_cnt = 0, cpu_rises = 0, cpd_rises = 0, cpu_falls = 0, cpd_falls = 0;
    int         done_cnt = 0, carry_cnt = 0, borrow_cnt = 0, carry_idx = 0, borrow_idx = 0;
    logic       cpu_s = 1'b1, cpd_s = 1'b1;
    logic [3:0] p_cap = 4'd0;

    always @(posedge clk) begin
        cpu_s <= CPU;
        cpd_s <= CPD;
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
        if (CPU && !cpu_s) cpu_rises <= cpu_rises + 1;
        if (!CPU && cpu_s) cpu_falls <= cpu_falls + 1;
        if (CPD && !cpd_s) cpd_rises <= cpd_rises + 1;
        if (!CPD && cpd_s) cpd_falls <= cpd_falls + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (carry_evt) begin carry_cnt <= carry_cnt + 1; carry_idx <= cpu_falls; end
        if (borrow_evt) begin borrow_cnt <= borrow_cnt + 1; borrow_idx <= cpd_falls; end
        if (!PL) p_cap <= {P0, P1, P2, P3};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Issue one command and wait (bounded) for its done pulse.
    task automatic do_cmd(input cmd_op_e op, input logic [3:0] data);
        int   n = 0;
        logic got = 1'b0;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!got && n < 400) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            got = done;
            n++;
        end
        check("done_wait", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    int   base_cpu, base_cpd, base_done, base_carry, base_borrow, base_acc;
    int   n;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 4'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ctl", {28'd0, MR, PL, CPU, CPD}, 32'h7);
        check("rst_p", {28'd0, P0, P1, P2, P3}, 32'h0);
        check("rst_model", {27'd0, exp_valid, exp_count}, 32'h0);
        check("rst_flags", {28'd0, done, mismatch, carry_evt, borrow_evt}, 32'h0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Clear then load 9.
        base_done = done_cnt;
        do_cmd(OP_CLEAR, 4'd0);
        check("clr_count", {28'd0, exp_count}, 32'd0);
        do_cmd(OP_LOAD, 4'd9);
        check("load_p", {28'd0, p_cap}, 32'h9);
        check("load_q", {28'd0, Q3, Q2, Q1, Q0}, 32'd9);
        check("load_exp", {27'd0, exp_valid, exp_count}, 32'h19);
        check("load_dones", done_cnt - base_done, 32'd2);
        check("load_mismatch", {31'd0, mismatch}, 32'd0);

        // Load 14, up 3 wraps through 15.
        do_cmd(OP_LOAD, 4'd14);
        base_cpu = cpu_rises; base_cpd = cpd_rises; base_carry = carry_cnt;
        n = cpu_falls;
        do_cmd(OP_UP, 4'd3);
        check("up_pulses", cpu_rises - base_cpu, 32'd3);
        check("up_cpd_idle", cpd_rises - base_cpd, 32'd0);
        check("up_carry_cnt", carry_cnt - base_carry, 32'd1);
        check("up_carry_idx", carry_idx - n, 32'd2);
        check("up_q", {28'd0, Q3, Q2, Q1, Q0}, 32'd1);
        check("up_exp", {28'd0, exp_count}, 32'd1);
        check("up_mismatch", {31'd0, mismatch}, 32'd0);

        // Clear, down 2 wraps through 0.
        do_cmd(OP_CLEAR, 4'd0);
        base_borrow = borrow_cnt; base_cpd = cpd_rises;
        n = cpd_falls;
        do_cmd(OP_DOWN, 4'd2);
        check("dn_pulses", cpd_rises - base_cpd, 32'd2);
        check("dn_borrow_cnt", borrow_cnt - base_borrow, 32'd1);
        check("dn_borrow_idx", borrow_idx - n, 32'd1);
        check("dn_exp", {28'd0, exp_count}, 32'd14);
        check("dn_q", {28'd0, Q3, Q2, Q1, Q0}, 32'd14);
        check("dn_mismatch", {31'd0, mismatch}, 32'd0);

        // UP 0: done on the cycle after acceptance, no clock edge.
        base_cpu = cpu_rises;
        wait_ready();
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("n0_done", {31'd0, done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("n0_no_pulse", cpu_rises - base_cpu, 32'd0);
        check("n0_exp", {28'd0, exp_count}, 32'd14);

        // cmd_valid held through a busy UP 2: exactly one acceptance.
        wait_ready();
        base_acc = acc_cnt; base_cpu = cpu_rises;
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd2;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        check("hs_done", {31'd0, done}, 32'd1);
        check("hs_busy_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("hs_accepts", acc_cnt - base_acc, 32'd1);
        check("hs_ready_back", {31'd0, cmd_ready}, 32'd1);
        check("hs_pulses", cpu_rises - base_cpu, 32'd2);
        check("hs_exp", {28'd0, exp_count}, 32'd0);

        // Counter answers 4 for a load of 5: sticky mismatch.
        fault_en = 1'b1; fault_q = 4'd4;
        do_cmd(OP_LOAD, 4'd5);
        check("flt_mismatch", {31'd0, mismatch}, 32'd1);
        fault_en = 1'b0;
        do_cmd(OP_CLEAR, 4'd0);
        check("flt_sticky", {31'd0, mismatch}, 32'd1);

        // Reset in the middle of a CPU low phase of UP 4.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd4;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("rp_cpu_low", {31'd0, CPU}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rp_cpu_high", {31'd0, CPU}, 32'd1);
        check("rp_flags", {29'd0, exp_valid, mismatch, cmd_ready}, 32'd0);
        base_done = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rp_ready", {31'd0, cmd_ready}, 32'd1);
        check("rp_valid", {31'd0, exp_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rp_no_done", done_cnt - base_done, 32'd0);

        // Model unknown: UP pulses but Q is not checked.
        fault_en = 1'b1; fault_q = 4'd7;
        base_cpu = cpu_rises;
        do_cmd(OP_UP, 4'd1);
        check("inv_pulse", cpu_rises - base_cpu, 32'd1);
        check("inv_no_mismatch", {31'd0, mismatch}, 32'd0);
        fault_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_driver.md
CONTADOR_DRIVER -- requirements
Module: contador_driver

Interface
REQ-001 Parameter PULSE_W, default 2: clk cycles each count pulse is held low, and MR high or PL low; legal range 1..15.
REQ-002 Parameter GAP_W, default 2: clk cycles of idle-high gap after each pulse before the next action; legal range 1..15.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  driver can accept a command.
REQ-007 cmd_op  in  2  0=CLEAR, 1=LOAD, 2=UP, 3=DOWN.
REQ-008 cmd_data  in  4  LOAD value, or UP/DOWN step count.
REQ-009 MR, PL, CPU, CPD  out  1 each  counter master reset (active-high), parallel load (active-low), up clock, down clock.
REQ-010 P0, P1, P2, P3  out  1 each  parallel data; P0 carries value bit 3, P3 carries value bit 0.
REQ-011 Q0, Q1, Q2, Q3, TCU, TCD  in  1 each  counter outputs; Q0 is the LSB.
REQ-012 exp_count  out  4  modelled counter value; exp_valid  out  1  model is known.
REQ-013 done  out  1  one-cycle pulse when a command completes.
REQ-014 mismatch  out  1  sticky error flag; cleared only by reset.
REQ-015 carry_evt, borrow_evt  out  1 each  one-cycle pulses on observed TCU or TCD low.

Function
REQ-016 Handshake: a command is accepted on a cycle where cmd_valid and cmd_ready are both 1; cmd_ready is 1 only in IDLE.
REQ-017 FSM states: IDLE, CLR, LOAD, PULSE, GAP, CHECK, DONE.
REQ-018 CLEAR: MR=1 for PULSE_W cycles, then GAP -> CHECK; model result = 0.
REQ-019 LOAD: P0..P3 set at acceptance and held stable; PL=0 for PULSE_W cycles, then GAP -> CHECK; model result = cmd_data.
REQ-020 UP: for each step, CPU=0 for PULSE_W cycles, rising to 1, then GAP, then CHECK; model +1 mod 16; CPD stays 1.
REQ-021 DOWN: same as UP using CPD; model -1 mod 16; CPU stays 1.
REQ-022 Step count: N steps are performed; N=0 produces no pulses and asserts done the cycle after acceptance.
REQ-023 Wrap-around: UP from 15 gives 0 and DOWN from 0 gives 15 in the model, with no special handling.
REQ-024 CHECK (one cycle): if exp_valid and {Q3,Q2,Q1,Q0} differs from exp_count, mismatch is set.
REQ-025 Terminal count during an UP pulse low phase: when exp_count=15, TCU=1 sets mismatch, and TCU=0 pulses carry_evt once per pulse.
REQ-026 Terminal count during a DOWN pulse low phase: when exp_count=0, the same rule applies to TCD and borrow_evt.
REQ-027 Terminal count outside those pulse low phases: TCU=0 or TCD=0 sets mismatch.
REQ-028 Idle levels: MR=0, PL=1, CPU=1, CPD=1; CPU and CPD are never low simultaneously.
REQ-029 Output registering: all counter-side outputs are driven directly from flops, with no combinational glitches.
REQ-030 Model validity: exp_valid=0 until the first CLEAR or LOAD completes; UP/DOWN while exp_valid=0 pulses normally and skips the Q and TC checks.
REQ-031 done asserts in DONE for one cycle; the FSM returns to IDLE on the next cycle.
REQ-032 A cmd_valid not accepted is ignored, with no queueing.

Reset
REQ-033 While rst_n=0, the FSM is in IDLE and all counters are cleared.
REQ-034 Output values while rst_n=0: MR=0, PL=1, CPU=1, CPD=1, P0..P3=0, exp_count=0, exp_valid=0, done=0, mismatch=0, carry_evt=0, borrow_evt=0, cmd_ready=0.
REQ-035 cmd_ready=1 from the first clk edge after rst_n rises.
REQ-036 Reset mid-operation aborts the command immediately: any low pulse returns high asynchronously and no done is issued.

Structure
REQ-037 The shared package contador_pkg holds the cmd_op enum (CLEAR, LOAD, UP, DOWN) and the FSM state enum.
REQ-038 One sub-module, contador_pulse_timer: a 4-bit down-counter loaded with PULSE_W or GAP_W that raises an expiry flag.

Verification
REQ-039 Bench scenario, clear then load: CLEAR, then LOAD 9 -> P0..P3=1,0,0,1 during PL low; Q=9 at CHECK; exp_count=9; done pulses twice; mismatch=0.
REQ-040 Bench scenario, up wrap: LOAD 14, then UP 3 -> exactly 3 CPU pulses; carry_evt once on the second pulse; final Q=1; mismatch=0.
REQ-041 Bench scenario, down wrap: CLEAR, then DOWN 2 -> borrow_evt on the first pulse; final exp_count=14.
REQ-042 Bench scenario, fault injection: LOAD 5 with the counter model forced to return Q=4 -> mismatch=1 after CHECK and stays 1 through later commands.
REQ-043 Bench scenario, N=0 and handshake: UP 0 -> no CPU edge and done one cycle after acceptance; cmd_valid held during busy -> no second acceptance until cmd_ready=1.
REQ-044 Bench scenario, reset mid-pulse: rst_n low during CPU low in UP 4 -> CPU=1 immediately; after release exp_valid=0, cmd_ready=1, and no done pulse.
